// File: rtl/gpio_irq_bank.sv
// GPIO bank on the peripheral bus: direction, output data with set/clear/toggle,
// synchronised inputs, per-pin edge detection with sticky W1C status and a registered irq.
module gpio_irq_bank #(
    parameter int unsigned NUM_PINS    = 16,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned MASK_W      = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_i,
    input  logic                we_i,
    input  logic [31:0]         addr_i,
    input  logic [31:0]         data_i,
    input  logic [MASK_W-1:0]   wem,
    output logic [31:0]         data_o,
    output logic                addr_ok,
    output logic                data_ok,
    input  logic [NUM_PINS-1:0] io_pin_i,
    output logic [NUM_PINS-1:0] io_pin_o,
    output logic [NUM_PINS-1:0] io_oe_o,
    output logic                irq_o
);

    localparam logic [3:0] REG_DIR     = 4'h0;
    localparam logic [3:0] REG_OUT     = 4'h1;
    localparam logic [3:0] REG_IN      = 4'h2;
    localparam logic [3:0] REG_SET     = 4'h3;
    localparam logic [3:0] REG_CLR     = 4'h4;
    localparam logic [3:0] REG_TGL     = 4'h5;
    localparam logic [3:0] REG_RISE_EN = 4'h6;
    localparam logic [3:0] REG_FALL_EN = 4'h7;
    localparam logic [3:0] REG_STATUS  = 4'h8;

    logic [NUM_PINS-1:0] dir_q, dir_d;
    logic [NUM_PINS-1:0] out_q, out_d;
    logic [NUM_PINS-1:0] rise_en_q, rise_en_d;
    logic [NUM_PINS-1:0] fall_en_q, fall_en_d;
    logic [NUM_PINS-1:0] status_q, status_d;
    logic [NUM_PINS-1:0] prev_q;
    logic [NUM_PINS-1:0] sync_q [SYNC_STAGES];
    logic [31:0]         data_o_q;
    logic                data_ok_q;
    logic                irq_q;

    logic [3:0]          reg_sel;
    logic                wr;
    logic                rd;
    logic [31:0]         byte_mask;
    logic [NUM_PINS-1:0] wmask;
    logic [NUM_PINS-1:0] wdata;
    logic [NUM_PINS-1:0] in_val;
    logic [NUM_PINS-1:0] edge_set;
    logic [NUM_PINS-1:0] status_clr;
    logic [NUM_PINS-1:0] rdata;
    logic [31:0]         rdata_ext;

    assign reg_sel = addr_i[5:2];
    assign wr      = req_i & we_i;
    assign rd      = req_i & ~we_i;
    assign addr_ok = req_i;

    always_comb begin
        byte_mask = '0;
        for (int k = 0; k < 4; k++) begin
            if (k < MASK_W) byte_mask[k*8 +: 8] = {8{wem[k]}};
        end
    end

    // Masked-off bytes contribute zeros, which makes set/clear/toggle no-ops there.
    assign wmask  = byte_mask[NUM_PINS-1:0];
    assign wdata  = data_i[NUM_PINS-1:0] & wmask;
    assign in_val = sync_q[SYNC_STAGES-1];

    // Only input pins can raise status.
    assign edge_set = ((in_val & ~prev_q & rise_en_q) | (~in_val & prev_q & fall_en_q)) & ~dir_q;

    always_comb begin
        dir_d      = dir_q;
        out_d      = out_q;
        rise_en_d  = rise_en_q;
        fall_en_d  = fall_en_q;
        status_clr = '0;
        if (wr) begin
            case (reg_sel)
                REG_DIR:     dir_d      = (dir_q & ~wmask) | wdata;
                REG_OUT:     out_d      = (out_q & ~wmask) | wdata;
                REG_SET:     out_d      = out_q | wdata;
                REG_CLR:     out_d      = out_q & ~wdata;
                REG_TGL:     out_d      = out_q ^ wdata;
                REG_RISE_EN: rise_en_d  = (rise_en_q & ~wmask) | wdata;
                REG_FALL_EN: fall_en_d  = (fall_en_q & ~wmask) | wdata;
                REG_STATUS:  status_clr = wdata;
                default:     ;
            endcase
        end
        // A new edge in the same cycle as its clear keeps the bit set.
        status_d = (status_q & ~status_clr) | edge_set;
    end

    always_comb begin
        rdata = '0;
        case (reg_sel)
            REG_DIR:     rdata = dir_q;
            REG_OUT:     rdata = out_q;
            REG_IN:      rdata = in_val;
            REG_RISE_EN: rdata = rise_en_q;
            REG_FALL_EN: rdata = fall_en_q;
            REG_STATUS:  rdata = status_q;
            default:     rdata = '0;
        endcase
        rdata_ext                 = '0;
        rdata_ext[NUM_PINS-1:0]   = rdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir_q     <= '0;
            out_q     <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            status_q  <= '0;
            prev_q    <= '0;
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
            data_o_q  <= '0;
            data_ok_q <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            dir_q     <= dir_d;
            out_q     <= out_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            status_q  <= status_d;
            prev_q    <= in_val;
            sync_q[0] <= io_pin_i;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
            data_o_q  <= rd ? rdata_ext : 32'h0;
            data_ok_q <= req_i;
            irq_q     <= |status_q;
        end
    end

    assign data_o   = data_o_q;
    assign data_ok  = data_ok_q;
    assign io_pin_o = out_q;
    assign io_oe_o  = dir_q;
    assign irq_o    = irq_q;

endmodule

// File: tb/tb_gpio_irq_bank.sv
// Scoreboard bench for gpio_irq_bank: expected read data is queued when an access is
// issued and popped when data_ok returns the next cycle.
module tb_gpio_irq_bank;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [31:0] data_i;
    logic [3:0]  wem;
    logic [31:0] data_o;
    logic        addr_ok;
    logic        data_ok;
    logic [15:0] io_pin_i;
    logic [15:0] io_pin_o;
    logic [15:0] io_oe_o;
    logic        irq_o;

    int vectors    = 0;
    int miscompares = 0;
    logic [31:0] exp_q [$];
    logic        obs_ok;
    logic [31:0] obs_data;
    logic [31:0] e;

    localparam logic [3:0] O_DIR = 4'h0, O_OUT = 4'h1, O_IN = 4'h2, O_SET = 4'h3;
    localparam logic [3:0] O_CLR = 4'h4, O_TGL = 4'h5, O_RISE = 4'h6, O_FALL = 4'h7;
    localparam logic [3:0] O_STAT = 4'h8;

    gpio_irq_bank #(.NUM_PINS(16), .SYNC_STAGES(2), .MASK_W(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_i    (req_i),
        .we_i     (we_i),
        .addr_i   (addr_i),
        .data_i   (data_i),
        .wem      (wem),
        .data_o   (data_o),
        .addr_ok  (addr_ok),
        .data_ok  (data_ok),
        .io_pin_i (io_pin_i),
        .io_pin_o (io_pin_o),
        .io_oe_o  (io_oe_o),
        .irq_o    (irq_o)
    );

    always #5 clk = ~clk;

    // One bus access; leaves time at 1 ns after the accepting edge with outputs captured.
    task automatic bus(input logic w, input logic [3:0] off, input logic [31:0] d,
                       input logic [3:0] m, input logic [31:0] expv);
        req_i  = 1'b1;
        we_i   = w;
        addr_i = {26'h0, off, 2'b00};
        data_i = d;
        wem    = m;
        exp_q.push_back(w ? 32'h0 : expv);
        @(posedge clk);
        #1;
        obs_ok   = data_ok;
        obs_data = data_o;
        req_i    = 1'b0;
        we_i     = 1'b0;
    endtask

    task automatic idle(input int n);
        req_i = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; req_i = 0; we_i = 0; addr_i = 0; data_i = 0; wem = 0; io_pin_i = 0;
        #12;
        vectors++;
        if ({data_o, data_ok, io_pin_o, io_oe_o, irq_o} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: data_o=%h ok=%b pin=%h oe=%h irq=%b, want all 0",
                     data_o, data_ok, io_pin_o, io_oe_o, irq_o);
        end
        rst_n = 1'b1;
        idle(1);
    endtask

    task automatic test_rw;
        logic [37:0] ops [4];
        ops[0] = {1'b1, O_DIR, 32'h0000_000F, 1'b0};
        ops[1] = {1'b1, O_OUT, 32'h0000_A5A5, 1'b0};
        ops[2] = {1'b0, O_DIR, 32'h0000_000F, 1'b0};
        ops[3] = {1'b0, O_OUT, 32'h0000_A5A5, 1'b0};
        for (int i = 0; i < 4; i++) begin
            bus(ops[i][37], ops[i][36:33], ops[i][32:1], 4'hF, ops[i][32:1]);
            e = exp_q.pop_front();
            vectors++;
            if (obs_ok !== 1'b1 || obs_data !== e) begin
                miscompares++;
                $display("FAIL rw[%0d]: data_ok=%b data_o=%h, want 1/%h", i, obs_ok, obs_data, e);
            end
        end
        vectors++;
        if (io_oe_o !== 16'h000F || io_pin_o !== 16'hA5A5) begin
            miscompares++;
            $display("FAIL pads: oe=%h pin=%h, want 000f/a5a5", io_oe_o, io_pin_o);
        end
        req_i = 1'b1;
        #1;
        vectors++;
        if (addr_ok !== 1'b1) begin
            miscompares++;
            $display("FAIL addr_ok: got %b, want 1", addr_ok);
        end
        req_i = 1'b0;
        #1;
    endtask

    task automatic test_back_to_back;
        logic [3:0]  offs [6] = '{O_OUT, O_SET, O_CLR, O_TGL, O_OUT, O_SET};
        logic [31:0] dats [6] = '{32'hF0, 32'h3, 32'h10, 32'h100, 32'h0, 32'h0};
        logic [31:0] exps [6] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h1E3, 32'h0};
        for (int i = 0; i < 6; i++) begin
            bus(i < 4, offs[i], dats[i], 4'hF, exps[i]);
            e = exp_q.pop_front();
            vectors++;
            if (obs_ok !== 1'b1 || obs_data !== e) begin
                miscompares++;
                $display("FAIL b2b[%0d]: data_ok=%b data_o=%h, want 1/%h", i, obs_ok, obs_data, e);
            end
        end
        idle(1);
        vectors++;
        if (data_ok !== 1'b0 || data_o !== 32'h0) begin
            miscompares++;
            $display("FAIL idle_bus: data_ok=%b data_o=%h, want 0/0", data_ok, data_o);
        end
    endtask

    task automatic test_mask;
        logic [3:0]  offs [6] = '{O_OUT, O_OUT, O_OUT, O_OUT, O_OUT, 4'h9};
        logic        wes  [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [3:0]  wms  [6] = '{4'hF, 4'h1, 4'hF, 4'hF, 4'hF, 4'hF};
        logic [31:0] dats [6] = '{32'h0, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0};
        logic [31:0] exps [6] = '{32'h0, 32'h0, 32'hFF, 32'h0, 32'hFFFF, 32'h0};
        for (int i = 0; i < 6; i++) begin
            bus(wes[i], offs[i], dats[i], wms[i], exps[i]);
            e = exp_q.pop_front();
            vectors++;
            if (obs_ok !== 1'b1 || obs_data !== e) begin
                miscompares++;
                $display("FAIL mask[%0d]: data_ok=%b data_o=%h, want 1/%h", i, obs_ok, obs_data, e);
            end
        end
    endtask

    task automatic test_rise;
        bus(1'b1, O_DIR, 32'h0, 4'hF, 32'h0);  void'(exp_q.pop_front());
        bus(1'b1, O_RISE, 32'h8, 4'hF, 32'h0); void'(exp_q.pop_front());
        io_pin_i = 16'h0008;
        idle(3);
        vectors++;
        if (irq_o !== 1'b0) begin
            miscompares++;
            $display("FAIL irq_early: irq=%b, want 0 at clk 3", irq_o);
        end
        idle(1);
        vectors++;
        if (irq_o !== 1'b1) begin
            miscompares++;
            $display("FAIL irq_rise: irq=%b, want 1 at clk 4", irq_o);
        end
        bus(1'b0, O_STAT, 32'h0, 4'hF, 32'h8);
        e = exp_q.pop_front(); vectors++;
        if (obs_ok !== 1'b1 || obs_data !== e) begin
            miscompares++;
            $display("FAIL status_rise: data_ok=%b data_o=%h, want 1/%h", obs_ok, obs_data, e);
        end
        bus(1'b0, O_IN, 32'h0, 4'hF, 32'h8);
        e = exp_q.pop_front(); vectors++;
        if (obs_ok !== 1'b1 || obs_data !== e) begin
            miscompares++;
            $display("FAIL in_read: data_ok=%b data_o=%h, want 1/%h", obs_ok, obs_data, e);
        end
        bus(1'b1, O_STAT, 32'h8, 4'hF, 32'h0); void'(exp_q.pop_front());
        vectors++;
        if (irq_o !== 1'b1) begin
            miscompares++;
            $display("FAIL irq_hold: irq=%b, want 1 one clk after W1C", irq_o);
        end
        idle(1);
        vectors++;
        if (irq_o !== 1'b0) begin
            miscompares++;
            $display("FAIL irq_clear: irq=%b, want 0 two clk after W1C", irq_o);
        end
        io_pin_i = 16'h0000;
        idle(5);
        bus(1'b0, O_STAT, 32'h0, 4'hF, 32'h0);
        e = exp_q.pop_front(); vectors++;
        if (obs_ok !== 1'b1 || obs_data !== e || irq_o !== 1'b0) begin
            miscompares++;
            $display("FAIL no_fall_irq: status=%h irq=%b, want %h/0", obs_data, irq_o, e);
        end
    endtask

    task automatic test_fall_w1c;
        bus(1'b1, O_FALL, 32'h1, 4'hF, 32'h0); void'(exp_q.pop_front());
        io_pin_i = 16'h0001;
        idle(4);
        io_pin_i = 16'h0000;
        idle(2);
        bus(1'b1, O_STAT, 32'h1, 4'hF, 32'h0); void'(exp_q.pop_front());
        bus(1'b0, O_STAT, 32'h0, 4'hF, 32'h1);
        e = exp_q.pop_front(); vectors++;
        if (obs_ok !== 1'b1 || obs_data !== e || irq_o !== 1'b1) begin
            miscompares++;
            $display("FAIL set_beats_clear: status=%h irq=%b, want %h/1", obs_data, irq_o, e);
        end
        bus(1'b1, O_FALL, 32'h0, 4'hF, 32'h0); void'(exp_q.pop_front());
        bus(1'b0, O_STAT, 32'h0, 4'hF, 32'h1);
        e = exp_q.pop_front(); vectors++;
        if (obs_data !== e) begin
            miscompares++;
            $display("FAIL sticky_after_disable: status=%h, want %h", obs_data, e);
        end
        bus(1'b1, O_STAT, 32'h1, 4'hF, 32'h0); void'(exp_q.pop_front());
        bus(1'b0, O_STAT, 32'h0, 4'hF, 32'h0);
        e = exp_q.pop_front(); vectors++;
        if (obs_data !== e) begin
            miscompares++;
            $display("FAIL w1c: status=%h, want %h", obs_data, e);
        end
    endtask

    task automatic test_output_pin_no_edge;
        bus(1'b1, O_DIR, 32'h1, 4'hF, 32'h0);  void'(exp_q.pop_front());
        bus(1'b1, O_FALL, 32'h1, 4'hF, 32'h0); void'(exp_q.pop_front());
        io_pin_i = 16'h0001;
        idle(4);
        io_pin_i = 16'h0000;
        idle(4);
        bus(1'b0, O_STAT, 32'h0, 4'hF, 32'h0);
        e = exp_q.pop_front(); vectors++;
        if (obs_data !== e) begin
            miscompares++;
            $display("FAIL dir_blocks_edge: status=%h, want %h", obs_data, e);
        end
    endtask

    task automatic test_reset_mid;
        bus(1'b1, O_DIR, 32'hF000, 4'hF, 32'h0);  void'(exp_q.pop_front());
        bus(1'b1, O_RISE, 32'hFFFF, 4'hF, 32'h0); void'(exp_q.pop_front());
        req_i = 1'b1; we_i = 1'b0; addr_i = {26'h0, O_STAT, 2'b00};
        #2;
        rst_n = 1'b0;
        io_pin_i = 16'hFFFF;
        #2;
        vectors++;
        if ({data_o, data_ok, io_pin_o, io_oe_o, irq_o} !== '0) begin
            miscompares++;
            $display("FAIL reset_mid: data_o=%h ok=%b pin=%h oe=%h irq=%b, want all 0",
                     data_o, data_ok, io_pin_o, io_oe_o, irq_o);
        end
        req_i = 1'b0;
        #10 io_pin_i = 16'h0000;
        #10 io_pin_i = 16'hFFFF;
        rst_n = 1'b1;
        idle(2);
        io_pin_i = 16'h0000;
        idle(2);
        io_pin_i = 16'h5A5A;
        idle(4);
        vectors++;
        if (irq_o !== 1'b0) begin
            miscompares++;
            $display("FAIL irq_after_reset: irq=%b, want 0", irq_o);
        end
        bus(1'b0, O_RISE, 32'h0, 4'hF, 32'h0);
        e = exp_q.pop_front(); vectors++;
        if (obs_ok !== 1'b1 || obs_data !== e) begin
            miscompares++;
            $display("FAIL rise_en_reset: data_ok=%b data_o=%h, want 1/%h", obs_ok, obs_data, e);
        end
        bus(1'b0, O_STAT, 32'h0, 4'hF, 32'h0);
        e = exp_q.pop_front(); vectors++;
        if (obs_ok !== 1'b1 || obs_data !== e) begin
            miscompares++;
            $display("FAIL status_reset: data_ok=%b data_o=%h, want 1/%h", obs_ok, obs_data, e);
        end
    endtask

    initial begin
        test_reset();
        test_rw();
        test_back_to_back();
        test_mask();
        test_rise();
        test_fall_w1c();
        test_output_pin_no_edge();
        test_reset_mid();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
